vector_check_engine: RTL

- Synthesizable, parametrised self-checking test engine for on-FPGA regression of calculator datapath blocks.
- Steps through a vector memory holding stimulus, expected response and a valid flag. Drives the DUT, compares its output after a fixed pipeline latency, counts vectors and errors, and captures the first failure.
- Sits between an external synchronous vector ROM/BRAM and any DUT with fixed latency. Results go to the board's display/LED logic.

---
 rtl/vector_check_engine_if.sv | 34 +++
 rtl/vector_check_engine.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vector_check_engine_if.sv
// rtl/vector_check_engine_if.sv - control, vector memory, DUT and result signals of the vector check engine
interface vector_check_engine_if #(
    parameter int IN_W   = 48,
    parameter int OUT_W  = 12,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic                    start;
    logic                    stop_on_err;
    logic [ADDR_W-1:0]       rom_addr;
    logic [IN_W+OUT_W:0]     rom_data;
    logic [IN_W-1:0]         dut_in;
    logic [OUT_W-1:0]        dut_out;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [CNT_W-1:0]        vec_count;
    logic [CNT_W-1:0]        err_count;
    logic [ADDR_W-1:0]       first_err_idx;
    logic [OUT_W-1:0]        first_err_got;
    logic [OUT_W-1:0]        first_err_exp;

    modport master (
        input  start, stop_on_err, rom_data, dut_out,
        output rom_addr, dut_in, busy, done, pass, vec_count, err_count,
               first_err_idx, first_err_got, first_err_exp
    );

    modport slave (
        output start, stop_on_err, rom_data, dut_out,
        input  rom_addr, dut_in, busy, done, pass, vec_count, err_count,
               first_err_idx, first_err_got, first_err_exp
    );
endinterface

// File: rtl/vector_check_engine.sv
// rtl/vector_check_engine.sv - walks a vector memory, drives a fixed-latency DUT and scores its responses
module vector_check_engine #(
    parameter int IN_W   = 48,
    parameter int OUT_W  = 12,
    parameter int ADDR_W = 10,
    parameter int LAT    = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    vector_check_engine_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [2:0]        state;
    logic              stop_lat;
    logic              err_seen;
    logic [ADDR_W-1:0] rom_addr;
    logic [ADDR_W-1:0] idx;
    logic [IN_W-1:0]   dut_in;
    logic [CNT_W-1:0]  vec_count;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] fe_idx;
    logic [OUT_W-1:0]  fe_got;
    logic [OUT_W-1:0]  fe_exp;

    // Stage 0 lines up with dut_in; stage LAT lines up with the DUT response.
    logic [LAT:0]      pv;
    logic [LAT:0]      pv_next;
    logic [OUT_W-1:0]  pexp [0:LAT];
    logic [ADDR_W-1:0] pidx [0:LAT];

    logic              rv;
    logic [IN_W-1:0]   rstim;
    logic [OUT_W-1:0]  rexp;
    logic              cmp, miss, abort, apply, last, pending;

    assign rv    = bus.rom_data[IN_W+OUT_W];
    assign rstim = bus.rom_data[IN_W+OUT_W-1:OUT_W];
    assign rexp  = bus.rom_data[OUT_W-1:0];

    always_comb begin
        cmp   = (state == S_RUN || state == S_DRAIN) && pv[LAT];
        miss  = cmp && (bus.dut_out != pexp[LAT]);
        abort = miss && stop_lat;
        apply = (state == S_RUN) && rv && !abort;
        last  = (state == S_RUN) && (!rv || idx == ADDR_MAX);
        pv_next    = '0;
        pv_next[0] = apply;
        for (int i = 1; i <= LAT; i++) pv_next[i] = pv[i-1];
        pending = |pv_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            stop_lat  <= 1'b0;
            err_seen  <= 1'b0;
            rom_addr  <= '0;
            idx       <= '0;
            dut_in    <= '0;
            vec_count <= '0;
            err_count <= '0;
            fe_idx    <= '0;
            fe_got    <= '0;
            fe_exp    <= '0;
            pv        <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pexp[i] <= '0;
                pidx[i] <= '0;
            end
        end else begin
            pexp[0] <= rexp;
            pidx[0] <= idx;
            for (int i = 1; i <= LAT; i++) begin
                pexp[i] <= pexp[i-1];
                pidx[i] <= pidx[i-1];
            end
            pv <= ((state == S_RUN || state == S_DRAIN) && !abort) ? pv_next : '0;

            if (cmp) begin
                if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_W'(1);
                if (miss) begin
                    if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                    if (!err_seen) begin
                        err_seen <= 1'b1;
                        fe_idx   <= pidx[LAT];
                        fe_got   <= bus.dut_out;
                        fe_exp   <= pexp[LAT];
                    end
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state     <= S_FETCH;
                        stop_lat  <= bus.stop_on_err;
                        err_seen  <= 1'b0;
                        rom_addr  <= '0;
                        vec_count <= '0;
                        err_count <= '0;
                        fe_idx    <= '0;
                        fe_got    <= '0;
                        fe_exp    <= '0;
                    end
                end
                S_FETCH: begin
                    if (rom_addr != ADDR_MAX) rom_addr <= rom_addr + ADDR_W'(1);
                    idx   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else begin
                        if (apply) begin
                            dut_in <= rstim;
                            if (rom_addr != ADDR_MAX) rom_addr <= rom_addr + ADDR_W'(1);
                            if (idx != ADDR_MAX) idx <= idx + ADDR_W'(1);
                        end
                        if (last) state <= pending ? S_DRAIN : S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (abort || !pending) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rom_addr      = rom_addr;
    assign bus.dut_in        = dut_in;
    assign bus.busy          = (state == S_FETCH) || (state == S_RUN) || (state == S_DRAIN);
    assign bus.done          = (state == S_DONE);
    assign bus.pass          = (state == S_DONE) && (err_count == '0) && (vec_count != '0);
    assign bus.vec_count     = vec_count;
    assign bus.err_count     = err_count;
    assign bus.first_err_idx = fe_idx;
    assign bus.first_err_got = fe_got;
    assign bus.first_err_exp = fe_exp;
endmodule
